// File: rtl/loop_driver.sv
// -----------------------------------------------------------------------------
// loop_driver
//
// Sequences a loop of hash rounds. An accepted start latches the requested
// iteration count. The block then alternates between launching a round
// (ISSUE) and waiting for that round to complete (WAIT) until the requested
// number of iterations has finished. It reports the completed-iteration count
// to an external limit checker. The sequence ends early if the checker raises
// `fail`, or if a round does not complete within TIMEOUT cycles.
//
// Parameters
//   TIMEOUT  maximum number of cycles spent in WAIT before aborting (1..65535)
//
// Ports
//   clk_i                     clock, all state changes on the rising edge
//   reset_i                   asynchronous active-high reset
//   start_i                   request to run a sequence (sampled in IDLE only)
//   target_i[15:0]            iteration count, latched on an accepted start
//   round_done_i              one-cycle pulse: current round finished
//   fail_i                    loop-limit violation from the limit checker
//   current_loop_actualize_i  iteration count echoed back by the limit checker
//   current_loop_o[15:0]      completed iterations, driven to the limit checker
//   stop_o                    one-cycle pulse ending the sequence
//   round_go_o                one-cycle pulse launching one hash round
//   busy_o                    high whenever the FSM is not IDLE
//   done_o                    one-cycle pulse on normal completion
//   aborted_o                 sticky: last sequence ended by fail or timeout
//   mismatch_o                sticky: echo disagreed with current_loop_o
// -----------------------------------------------------------------------------
module loop_driver #(
  parameter int unsigned TIMEOUT = 256
) (
  input  logic        clk_i,
  input  logic        reset_i,
  input  logic        start_i,
  input  logic [15:0] target_i,
  input  logic        round_done_i,
  input  logic        fail_i,
  input  logic [15:0] current_loop_actualize_i,
  output logic [15:0] current_loop_o,
  output logic        stop_o,
  output logic        round_go_o,
  output logic        busy_o,
  output logic        done_o,
  output logic        aborted_o,
  output logic        mismatch_o
);

  // Value of the WAIT cycle counter on the final permitted WAIT cycle.
  localparam logic [15:0] WAIT_LAST = 16'(TIMEOUT - 1);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_ISSUE  = 3'd1,
    S_WAIT   = 3'd2,
    S_FINISH = 3'd3,
    S_ABORT  = 3'd4
  } state_t;

  state_t      state_q, state_d;
  logic [15:0] target_q, target_d;
  logic [15:0] loop_q, loop_d;
  logic [15:0] wait_cnt_q, wait_cnt_d;
  logic        aborted_q, aborted_d;
  logic        mismatch_q, mismatch_d;
  logic        round_go_q, round_go_d;
  logic        stop_q, stop_d;
  logic        done_q, done_d;
  logic        busy_q, busy_d;

  logic [15:0] loop_inc;
  logic [15:0] wait_inc;

  assign loop_inc = loop_q + 16'd1;
  assign wait_inc = wait_cnt_q + 16'd1;

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d    = state_q;
    target_d   = target_q;
    loop_d     = loop_q;
    wait_cnt_d = wait_cnt_q;
    aborted_d  = aborted_q;
    mismatch_d = mismatch_q;

    unique case (state_q)
      S_IDLE: begin
        if (start_i) begin
          target_d   = target_i;
          loop_d     = 16'd0;
          aborted_d  = 1'b0;
          mismatch_d = 1'b0;
          wait_cnt_d = 16'd0;
          // A zero-iteration request completes at once without any round.
          state_d    = (target_i == 16'd0) ? S_FINISH : S_ISSUE;
        end
      end

      S_ISSUE: begin
        // The checker's echo must track the count we are driving to it.
        if (current_loop_actualize_i != loop_q) begin
          mismatch_d = 1'b1;
        end
        wait_cnt_d = 16'd0;
        state_d    = fail_i ? S_ABORT : S_WAIT;
      end

      S_WAIT: begin
        // Priority: fail, then round completion, then timeout.
        if (fail_i) begin
          state_d = S_ABORT;
        end else if (round_done_i) begin
          loop_d  = loop_inc;
          state_d = (loop_inc == target_q) ? S_FINISH : S_ISSUE;
        end else if (wait_cnt_q == WAIT_LAST) begin
          state_d = S_ABORT;
        end else begin
          wait_cnt_d = wait_inc;
        end
      end

      S_FINISH: state_d = S_IDLE;
      S_ABORT:  state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase

    // Outputs are registered from the state being entered, so each pulse
    // lines up exactly with the cycle spent in the corresponding state.
    round_go_d = (state_d == S_ISSUE);
    stop_d     = (state_d == S_FINISH) || (state_d == S_ABORT);
    done_d     = (state_d == S_FINISH);
    busy_d     = (state_d != S_IDLE);
    if (state_d == S_ABORT) begin
      aborted_d = 1'b1;
    end
  end

  // ---------------------------------------------------------------------------
  // State and output registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state_q    <= S_IDLE;
      target_q   <= 16'd0;
      loop_q     <= 16'd0;
      wait_cnt_q <= 16'd0;
      aborted_q  <= 1'b0;
      mismatch_q <= 1'b0;
      round_go_q <= 1'b0;
      stop_q     <= 1'b0;
      done_q     <= 1'b0;
      busy_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      target_q   <= target_d;
      loop_q     <= loop_d;
      wait_cnt_q <= wait_cnt_d;
      aborted_q  <= aborted_d;
      mismatch_q <= mismatch_d;
      round_go_q <= round_go_d;
      stop_q     <= stop_d;
      done_q     <= done_d;
      busy_q     <= busy_d;
    end
  end

  assign current_loop_o = loop_q;
  assign stop_o         = stop_q;
  assign round_go_o     = round_go_q;
  assign busy_o         = busy_q;
  assign done_o         = done_q;
  assign aborted_o      = aborted_q;
  assign mismatch_o     = mismatch_q;

endmodule

// File: tb/tb_loop_driver.sv
// -----------------------------------------------------------------------------
// tb_loop_driver
//
// Each sequence is described by a plan: the target count, the number of WAIT
// cycles before each round_done, the echo value returned in each ISSUE cycle,
// and an optional fail point. From the plan the bench derives a period-by-
// period schedule (which period launches each round, when rounds complete,
// when the sequence ends and how). Expected outputs follow from that schedule.
// Period 0 is the cycle in which start is presented.
// -----------------------------------------------------------------------------
module tb_loop_driver;

  localparam int T    = 8;
  localparam int MAXP = 512;
  localparam int MAXK = 64;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [15:0] target;
  logic        round_done;
  logic        fail;
  logic [15:0] echo;
  logic [15:0] current_loop;
  logic        stop;
  logic        round_go;
  logic        busy;
  logic        done;
  logic        aborted;
  logic        mismatch;

  always #5 clk = ~clk;

  loop_driver #(.TIMEOUT(T)) dut (
    .clk_i                    (clk),
    .reset_i                  (reset),
    .start_i                  (start),
    .target_i                 (target),
    .round_done_i             (round_done),
    .fail_i                   (fail),
    .current_loop_actualize_i (echo),
    .current_loop_o           (current_loop),
    .stop_o                   (stop),
    .round_go_o               (round_go),
    .busy_o                   (busy),
    .done_o                   (done),
    .aborted_o                (aborted),
    .mismatch_o               (mismatch)
  );

  int checks   = 0;
  int failures = 0;

  task automatic check_eq(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // ---------------- plan ----------------
  int          tgt;
  int          dly    [MAXK];   // WAIT cycles before round_done; >= T means withheld
  logic [15:0] echo_v [MAXK];
  int          fail_iter;       // -1: no fail
  int          fail_off;        // 0: ISSUE cycle, j>0: j-th WAIT cycle

  // ---------------- schedule ----------------
  bit          s_go   [MAXP];
  bit          s_rd   [MAXP];
  bit          s_fail [MAXP];
  bit          s_acc  [MAXP];
  bit          s_bad  [MAXP];
  logic [15:0] s_echo [MAXP];
  int          end_p;
  bit          end_abort;

  logic [15:0] prev_loop = 16'd0;
  bit          prev_ab   = 1'b0;
  bit          prev_mis  = 1'b0;

  function automatic void set_plan(input int t, input int d);
    tgt       = t;
    fail_iter = -1;
    fail_off  = 0;
    for (int k = 0; k < MAXK; k++) begin
      dly[k]    = d;
      echo_v[k] = 16'(k);
    end
  endfunction

  function automatic void gen_random();
    int r;
    r = int'($urandom_range(0, 9));
    tgt = (r == 0) ? 0 : (r < 7) ? int'($urandom_range(1, 5)) : int'($urandom_range(6, 12));
    fail_iter = -1;
    fail_off  = 0;
    for (int k = 0; k < MAXK; k++) begin
      dly[k]    = ($urandom_range(0, 9) == 0) ? T - 1 : int'($urandom_range(0, 4));
      echo_v[k] = ($urandom_range(0, 3) == 0) ? 16'($urandom) : 16'(k);
    end
    if (tgt > 0 && $urandom_range(0, 7) == 0) dly[$urandom_range(0, tgt - 1)] = T;
    if (tgt > 0 && $urandom_range(0, 4) == 0) begin
      fail_iter = int'($urandom_range(0, tgt - 1));
      fail_off  = int'($urandom_range(0, 3));
    end
  endfunction

  function automatic void build_schedule();
    int  p;
    int  ip;
    int  w;
    bit  adv;
    bit  f;
    bit  r;
    for (int i = 0; i < MAXP; i++) begin
      s_go[i] = 0; s_rd[i] = 0; s_fail[i] = 0; s_acc[i] = 0; s_bad[i] = 0; s_echo[i] = 16'd0;
    end
    end_p     = 0;
    end_abort = 0;
    p         = 1;
    if (tgt == 0) begin
      end_p = 1;
      return;
    end
    for (int k = 0; k < tgt && end_p == 0; k++) begin
      ip         = p;
      s_go[ip]   = 1;
      s_echo[ip] = echo_v[k];
      s_bad[ip]  = (echo_v[k] != 16'(k));
      if (fail_iter == k && fail_off == 0) begin
        s_fail[ip] = 1;
        s_echo[ip] = 16'(k);
        s_bad[ip]  = 0;
        end_p      = ip + 1;
        end_abort  = 1;
      end else begin
        adv = 0;
        for (int j = 0; j < T && end_p == 0 && !adv; j++) begin
          w = ip + 1 + j;
          f = (fail_iter == k && fail_off == j + 1);
          r = (dly[k] == j);
          s_rd[w]   = r;
          s_fail[w] = f;
          if (f) begin
            end_p = w + 1; end_abort = 1;
          end else if (r) begin
            s_acc[w] = 1;
            if (k == tgt - 1) end_p = w + 1;
            else begin p = w + 1; adv = 1; end
          end else if (j == T - 1) begin
            end_p = w + 1; end_abort = 1;
          end
        end
      end
    end
  endfunction

  task automatic run_seq(input int sn);
    logic [15:0] run_loop;
    bit          run_mis;
    bit          ab_exp;
    string       b;
    build_schedule();
    run_loop = 16'd0;
    run_mis  = 0;
    for (int p = 0; p <= end_p + 2; p++) begin
      @(posedge clk);
      #1;
      start      = (p == 0) ? 1'b1 : (p <= end_p) ? 1'($urandom_range(0, 1)) : 1'b0;
      target     = (p == 0) ? 16'(tgt) : 16'($urandom);
      round_done = s_rd[p] | ((p == 0 || s_go[p] || p >= end_p) && $urandom_range(0, 2) == 0);
      fail       = s_fail[p] | ((p == 0 || p >= end_p) && $urandom_range(0, 2) == 0);
      echo       = s_go[p] ? s_echo[p] : 16'($urandom);
      @(negedge clk);
      b = $sformatf("s%0d p%0d", sn, p);
      check_eq({b, " round_go"}, 16'(round_go), 16'(p > 0 && s_go[p]));
      check_eq({b, " stop"},     16'(stop),     16'(p == end_p));
      check_eq({b, " done"},     16'(done),     16'(p == end_p && !end_abort));
      check_eq({b, " busy"},     16'(busy),     16'(p >= 1 && p <= end_p));
      if (p == 0) begin
        check_eq({b, " loop"},     current_loop,  prev_loop);
        check_eq({b, " mismatch"}, 16'(mismatch), 16'(prev_mis));
        check_eq({b, " aborted"},  16'(aborted),  16'(prev_ab));
      end else begin
        check_eq({b, " loop"},     current_loop,  run_loop);
        check_eq({b, " mismatch"}, 16'(mismatch), 16'(run_mis));
        if (p != end_p) begin
          ab_exp = (p > end_p) ? end_abort : 1'b0;
          check_eq({b, " aborted"}, 16'(aborted), 16'(ab_exp));
        end
        if (s_acc[p]) run_loop = run_loop + 16'd1;
        if (s_bad[p]) run_mis  = 1;
      end
    end
    prev_loop = run_loop;
    prev_ab   = end_abort;
    prev_mis  = run_mis;
    $display("seq %0d target=%0d periods=%0d aborted=%0d loop=%0d echo_bad=%0d",
             sn, tgt, end_p, end_abort, run_loop, run_mis);
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; target = 16'd0; round_done = 1'b0; fail = 1'b0; echo = 16'd0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check_eq("rst loop",     current_loop,  16'd0);
    check_eq("rst stop",     16'(stop),     16'd0);
    check_eq("rst round_go", 16'(round_go), 16'd0);
    check_eq("rst busy",     16'(busy),     16'd0);
    check_eq("rst done",     16'(done),     16'd0);
    check_eq("rst aborted",  16'(aborted),  16'd0);
    check_eq("rst mismatch", 16'(mismatch), 16'd0);
    reset = 1'b0;

    // Three iterations, round_done two cycles after each round_go.
    set_plan(3, 1);
    run_seq(0);
    // Zero-iteration request.
    set_plan(0, 0);
    run_seq(1);
    // Fail coincides with round_done in the second iteration's WAIT.
    set_plan(5, 1);
    fail_iter = 1; fail_off = 2;
    run_seq(2);
    // round_done withheld after the first round_go: timeout.
    set_plan(3, 1);
    dly[0] = T;
    run_seq(3);
    // Echo stuck at zero.
    set_plan(2, 1);
    echo_v[1] = 16'd0;
    run_seq(4);
    // Fail in an ISSUE cycle, and round_done on the last legal WAIT cycle.
    set_plan(3, T - 1);
    run_seq(5);
    set_plan(4, 0);
    fail_iter = 2; fail_off = 0;
    run_seq(6);

    // Reset raised in the middle of a WAIT.
    @(posedge clk); #1; start = 1'b1; target = 16'd4; round_done = 1'b0; fail = 1'b0; echo = 16'd0;
    @(posedge clk); #1; start = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    @(negedge clk);
    check_eq("mid busy", 16'(busy), 16'd1);
    #2 reset = 1'b1;
    #1;
    check_eq("arst loop",     current_loop,  16'd0);
    check_eq("arst stop",     16'(stop),     16'd0);
    check_eq("arst round_go", 16'(round_go), 16'd0);
    check_eq("arst busy",     16'(busy),     16'd0);
    check_eq("arst done",     16'(done),     16'd0);
    check_eq("arst aborted",  16'(aborted),  16'd0);
    check_eq("arst mismatch", 16'(mismatch), 16'd0);
    @(posedge clk); #1; reset = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check_eq($sformatf("post %0d go/stop/busy/done", i),
               {12'd0, round_go, stop, busy, done}, 16'd0);
    end
    prev_loop = 16'd0; prev_ab = 0; prev_mis = 0;
    $display("seq reset-in-wait target=4 outputs cleared");
    set_plan(4, 2);
    run_seq(7);

    for (int s = 8; s < 48; s++) begin
      gen_random();
      run_seq(s);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/loop_driver.md
LOOP_DRIVER -- requirements
Module: loop_driver

Interface
REQ-001 Parameter TIMEOUT, default 256: maximum cycles spent in WAIT before abort, range 1..65535.
REQ-002 clk  input  1  single clock; all state changes on its rising edge.
REQ-003 reset  input  1  asynchronous, active-high; forces reset state immediately, released synchronously to clk.
REQ-004 start  input  1  request to run a loop sequence; sampled in IDLE only.
REQ-005 target  input  16  number of iterations requested; latched on accepted start.
REQ-006 round_done  input  1  one-cycle pulse from the hash round: current iteration finished.
REQ-007 fail  input  1  loop-limit violation from the limit checker.
REQ-008 current_loop_actualize  input  16  iteration count echoed back by the limit checker.
REQ-009 current_loop  output  16  registered count of completed iterations, driven to the limit checker.
REQ-010 stop  output  1  one-cycle pulse ending the sequence, driven to the limit checker.
REQ-011 round_go  output  1  one-cycle pulse launching one hash round.
REQ-012 busy  output  1  high in every state except IDLE.
REQ-013 done  output  1  one-cycle pulse on normal completion.
REQ-014 aborted  output  1  sticky: last sequence ended by fail or timeout.
REQ-015 mismatch  output  1  sticky: echo disagreed with current_loop.

Function
REQ-016 States IDLE, ISSUE, WAIT, FINISH, ABORT, one-hot or binary, all outputs registered.
REQ-017 IDLE + start, target!=0: latch target_q, current_loop<=0, aborted<=0, mismatch<=0, wait_cnt<=0 -> ISSUE.
REQ-018 IDLE + start, target==0: clear aborted/mismatch, current_loop<=0 -> FINISH.
REQ-019 start outside IDLE is ignored; target is not re-latched.
REQ-020 ISSUE: round_go=1 for exactly this cycle; compare current_loop_actualize to current_loop, set mismatch on inequality; -> WAIT with wait_cnt<=0.
REQ-021 WAIT + round_done: current_loop<=current_loop+1; if current_loop+1==target_q -> FINISH, else -> ISSUE.
REQ-022 WAIT without round_done: wait_cnt increments; wait_cnt==TIMEOUT-1 without round_done -> ABORT.
REQ-023 fail high in ISSUE or WAIT -> ABORT, priority over round_done and timeout in the same cycle; current_loop not incremented that cycle.
REQ-024 fail in IDLE, FINISH or ABORT has no effect.
REQ-025 round_done outside WAIT is ignored.
REQ-026 FINISH: stop=1, done=1 for one cycle -> IDLE; current_loop holds final value.
REQ-027 ABORT: stop=1 for one cycle, aborted<=1, done stays 0 -> IDLE.
REQ-028 current_loop never exceeds target_q; 16-bit arithmetic, no wrap possible (max 65535 iterations).
REQ-029 Latency: start accepted at edge N, first round_go at cycle N+1; last round_done at edge M, stop/done at cycle M+1.
REQ-030 current_loop, aborted, mismatch hold their values in IDLE until the next accepted start.

Reset
REQ-031 On reset: state IDLE; current_loop=0, stop=0, round_go=0, busy=0, done=0, aborted=0, mismatch=0, target_q=0, wait_cnt=0.
REQ-032 Reset asserted mid-sequence aborts immediately without a stop pulse; no pending round_go is issued after release.

Verification
REQ-033 target=3, round_done 2 cycles after each round_go, echo=current_loop -> 3 round_go pulses, current_loop 0,1,2,3, one stop+done pulse, aborted=0, mismatch=0.
REQ-034 target=0, start -> next cycle FINISH: stop=1, done=1 one cycle, round_go never asserted, current_loop=0.
REQ-035 target=5, fail and round_done together in WAIT of 2nd iteration -> current_loop stays 1, stop pulse, aborted=1, done=0.
REQ-036 TIMEOUT=8, round_done withheld after first round_go -> ABORT after 8 WAIT cycles, stop pulse, aborted=1, current_loop=0.
REQ-037 reset raised during WAIT of a target=4 run -> all outputs 0 asynchronously, busy=0, no stop pulse; new start afterwards runs normally.
REQ-038 target=2, current_loop_actualize held at 0 -> mismatch=1 from second ISSUE onward, sequence still completes with done, current_loop=2.
